// File: rtl/pipes.sv
// pipes: shared pipeline-control types.
//   reset_t    - per-pipeline-register command: pass data or insert a bubble
//   hz_state_t - hazard_ctrl redirect-tracking state
package pipes;

  typedef enum logic {
    RESET_CONTINUE = 1'b0,
    RESET_RESET    = 1'b1
  } reset_t;

  typedef enum logic {
    RUN           = 1'b0,
    REDIRECT_PEND = 1'b1
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
// Ports:
//   clk   - clock
//   reset - synchronous active-high clear
//   inc   - count this cycle
//   count - current value
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the IF/ID, ID/EX and EX/MEM registers.
// Resolves fetch waits, data-memory waits, load-use hazards and EX redirects
// into per-register reset_t commands, hold signals and a PC redirect. A
// redirect resolved while a fetch is outstanding is parked in pend_pc and
// applied when that fetch completes.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   i_req, i_data_ok               - ibus request outstanding / data returned
//   d_req, d_data_ok               - dbus request outstanding / access done
//   id_rs1/2, id_use_rs1/2         - ID source registers and their use flags
//   ex_is_load, ex_dst             - EX load flag and destination register
//   ex_redirect, ex_redirect_pc    - EX taken branch/jump and its target
//   Iwait, Dwait                   - decoded bus waits
//   stall_pc, stall_IF_ID          - hold PC / IF-ID contents
//   reset_IF_ID/ID_EX/EX_MEM       - bubble or pass per pipeline register
//   redirect_valid, redirect_pc    - load PC with target this cycle
//   stall_cycles, flush_count      - saturating performance counters
module hazard_ctrl
  import pipes::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic             i_data_ok,
  input  logic             d_req,
  input  logic             d_data_ok,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_dst,
  input  logic             ex_redirect,
  input  logic [63:0]      ex_redirect_pc,
  output logic             Iwait,
  output logic             Dwait,
  output logic             stall_pc,
  output logic             stall_IF_ID,
  output reset_t           reset_IF_ID,
  output reset_t           reset_ID_EX,
  output reset_t           reset_EX_MEM,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_t   r_state, w_state_d;
  logic [63:0] r_pend_pc, w_pend_pc_d;
  logic        w_load_use;
  logic        w_flush_inc;
  logic        w_stall_inc;

  assign Iwait = i_req & ~i_data_ok;
  assign Dwait = d_req & ~d_data_ok;

  // x0 is never a real dependency.
  assign w_load_use = ex_is_load && (ex_dst != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_dst)) ||
                       (id_use_rs2 && (id_rs2 == ex_dst)));

  always_comb begin
    w_state_d      = r_state;
    w_pend_pc_d    = r_pend_pc;
    stall_pc       = 1'b0;
    stall_IF_ID    = 1'b0;
    reset_IF_ID    = RESET_CONTINUE;
    reset_ID_EX    = RESET_CONTINUE;
    reset_EX_MEM   = RESET_CONTINUE;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    w_flush_inc    = 1'b0;

    if (reset) begin
      w_state_d    = RUN;
      w_pend_pc_d  = 64'd0;
      reset_IF_ID  = RESET_RESET;
      reset_ID_EX  = RESET_RESET;
      reset_EX_MEM = RESET_RESET;
    end else if (Dwait) begin
      // Freeze everything; EX re-presents any redirect once the wait ends.
      stall_pc    = 1'b1;
      stall_IF_ID = 1'b1;
    end else if (r_state == REDIRECT_PEND) begin
      // Keep bubbling IF/ID so the wrong-path fetch is discarded.
      stall_pc    = 1'b1;
      reset_IF_ID = RESET_RESET;
      if (!Iwait) begin
        redirect_valid = 1'b1;
        redirect_pc    = r_pend_pc;
        w_state_d      = RUN;
      end
    end else if (ex_redirect) begin
      reset_IF_ID = RESET_RESET;
      reset_ID_EX = RESET_RESET;
      w_flush_inc = 1'b1;
      if (Iwait) begin
        stall_pc    = 1'b1;
        w_pend_pc_d = ex_redirect_pc;
        w_state_d   = REDIRECT_PEND;
      end else begin
        redirect_valid = 1'b1;
        redirect_pc    = ex_redirect_pc;
      end
    end else if (w_load_use) begin
      stall_pc    = 1'b1;
      stall_IF_ID = 1'b1;
      reset_ID_EX = RESET_RESET;
    end else if (Iwait) begin
      stall_pc    = 1'b1;
      reset_IF_ID = RESET_RESET;
    end
  end

  assign w_stall_inc = stall_pc & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_pend_pc <= 64'd0;
    end else begin
      r_state   <= w_state_d;
      r_pend_pc <= w_pend_pc_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_stall_inc),
    .count(stall_cycles)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_flush_inc),
    .count(flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import pipes::*;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_req, i_data_ok, d_req, d_data_ok;
  logic [4:0]       id_rs1, id_rs2, ex_dst;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
  logic [63:0]      ex_redirect_pc;
  logic             Iwait, Dwait, stall_pc, stall_IF_ID, redirect_valid;
  reset_t           reset_IF_ID, reset_ID_EX, reset_EX_MEM;
  logic [63:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req         (i_req),
    .i_data_ok     (i_data_ok),
    .d_req         (d_req),
    .d_data_ok     (d_data_ok),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_is_load    (ex_is_load),
    .ex_dst        (ex_dst),
    .ex_redirect   (ex_redirect),
    .ex_redirect_pc(ex_redirect_pc),
    .Iwait         (Iwait),
    .Dwait         (Dwait),
    .stall_pc      (stall_pc),
    .stall_IF_ID   (stall_IF_ID),
    .reset_IF_ID   (reset_IF_ID),
    .reset_ID_EX   (reset_ID_EX),
    .reset_EX_MEM  (reset_EX_MEM),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_data_ok = 0; d_req = 0; d_data_ok = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_is_load = 0; ex_dst = 0; ex_redirect = 0; ex_redirect_pc = 64'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Packs {stall_pc, stall_IF_ID, reset_IF_ID, reset_ID_EX, reset_EX_MEM, redirect_valid}.
  function automatic logic [5:0] ctl();
    return {stall_pc, stall_IF_ID, reset_IF_ID == RESET_RESET, reset_ID_EX == RESET_RESET,
            reset_EX_MEM == RESET_RESET, redirect_valid};
  endfunction

  task automatic test_reset();
    clear_inputs();
    i_req = 1; ex_redirect = 1; ex_redirect_pc = 64'h55;
    reset = 1'b1;
    tick();
    checks++; if (ctl() !== 6'b001110) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl(), 6'b001110); end
    checks++; if (redirect_pc !== 64'd0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", redirect_pc); end
    checks++; if ({stall_cycles, flush_count} !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %0h expected 0", {stall_cycles, flush_count}); end
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL idle_ctl: got %b expected %b", ctl(), 6'b000000); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load = 1; ex_dst = 5; id_rs1 = 5; id_use_rs1 = 1; #1;
    checks++; if (ctl() !== 6'b110100) begin errors++; $display("FAIL lu_rs1: got %b expected %b", ctl(), 6'b110100); end
    tick();
    ex_is_load = 0; ex_dst = 0; #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL lu_clear: got %b expected %b", ctl(), 6'b000000); end
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_stallcnt: got %0d expected 1", stall_cycles); end
    // x0 destination: no hazard
    ex_is_load = 1; ex_dst = 0; id_rs1 = 0; #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL lu_x0: got %b expected %b", ctl(), 6'b000000); end
    // rs2 match but not used: no hazard; then used: hazard
    ex_dst = 7; id_rs1 = 3; id_rs2 = 7; id_use_rs2 = 0; #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL lu_rs2_unused: got %b expected %b", ctl(), 6'b000000); end
    id_use_rs2 = 1; #1;
    checks++; if (ctl() !== 6'b110100) begin errors++; $display("FAIL lu_rs2: got %b expected %b", ctl(), 6'b110100); end
    // not a load: no hazard
    ex_is_load = 0; #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL lu_noload: got %b expected %b", ctl(), 6'b000000); end
  endtask

  task automatic test_redirect();
    do_reset();
    ex_redirect = 1; ex_redirect_pc = 64'h8000_0100; #1;
    checks++; if (ctl() !== 6'b001101) begin errors++; $display("FAIL rd_ctl: got %b expected %b", ctl(), 6'b001101); end
    checks++; if (redirect_pc !== 64'h8000_0100) begin errors++; $display("FAIL rd_pc: got %0h expected 80000100", redirect_pc); end
    tick();
    ex_redirect = 0; #1;
    checks++; if (flush_count !== 4'd1) begin errors++; $display("FAIL rd_flushcnt: got %0d expected 1", flush_count); end
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL rd_after: got %b expected %b", ctl(), 6'b000000); end
  endtask

  task automatic test_redirect_pend();
    do_reset();
    i_req = 1; ex_redirect = 1; ex_redirect_pc = 64'h1234; #1;
    checks++; if (ctl() !== 6'b101100) begin errors++; $display("FAIL pend_enter: got %b expected %b", ctl(), 6'b101100); end
    tick();
    // Redirect seen in REDIRECT_PEND must be ignored.
    ex_redirect_pc = 64'hDEAD;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctl() !== 6'b101000) begin errors++; $display("FAIL pend_wait%0d: got %b expected %b", i, ctl(), 6'b101000); end
      tick();
    end
    ex_redirect = 0; i_data_ok = 1; #1;
    checks++; if (ctl() !== 6'b101001) begin errors++; $display("FAIL pend_fire: got %b expected %b", ctl(), 6'b101001); end
    checks++; if (redirect_pc !== 64'h1234) begin errors++; $display("FAIL pend_pc: got %0h expected 1234", redirect_pc); end
    tick();
    i_req = 0; i_data_ok = 0; #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL pend_done: got %b expected %b", ctl(), 6'b000000); end
    checks++; if (flush_count !== 4'd1) begin errors++; $display("FAIL pend_flushcnt: got %0d expected 1", flush_count); end
    checks++; if (stall_cycles !== 4'd4) begin errors++; $display("FAIL pend_stallcnt: got %0d expected 4", stall_cycles); end
  endtask

  task automatic test_dwait();
    do_reset();
    d_req = 1; i_req = 1; ex_redirect = 1; ex_redirect_pc = 64'h40;
    ex_is_load = 1; ex_dst = 9; id_rs1 = 9; id_use_rs1 = 1; #1;
    checks++; if ({Iwait, Dwait} !== 2'b11) begin errors++; $display("FAIL dw_waits: got %b expected 11", {Iwait, Dwait}); end
    checks++; if (ctl() !== 6'b110000) begin errors++; $display("FAIL dw_ctl: got %b expected %b", ctl(), 6'b110000); end
    tick(); tick();
    checks++; if (ctl() !== 6'b110000) begin errors++; $display("FAIL dw_hold: got %b expected %b", ctl(), 6'b110000); end
    checks++; if (flush_count !== 4'd0) begin errors++; $display("FAIL dw_noflush: got %0d expected 0", flush_count); end
    d_data_ok = 1; i_req = 0; ex_is_load = 0; #1;
    checks++; if (ctl() !== 6'b001101) begin errors++; $display("FAIL dw_fire: got %b expected %b", ctl(), 6'b001101); end
    checks++; if (redirect_pc !== 64'h40) begin errors++; $display("FAIL dw_pc: got %0h expected 40", redirect_pc); end
    tick();
    checks++; if (flush_count !== 4'd1) begin errors++; $display("FAIL dw_flushcnt: got %0d expected 1", flush_count); end
  endtask

  task automatic test_reset_in_pend();
    do_reset();
    i_req = 1; ex_redirect = 1; ex_redirect_pc = 64'h777; #1;
    tick();
    ex_redirect = 0; i_data_ok = 1; reset = 1; #1;
    checks++; if (ctl() !== 6'b001110) begin errors++; $display("FAIL rp_ctl: got %b expected %b", ctl(), 6'b001110); end
    tick();
    reset = 0; #1;
    checks++; if (ctl() !== 6'b000000) begin errors++; $display("FAIL rp_after: got %b expected %b", ctl(), 6'b000000); end
    checks++; if ({stall_cycles, flush_count} !== 8'h00) begin errors++; $display("FAIL rp_cnt: got %0h expected 0", {stall_cycles, flush_count}); end
  endtask

  task automatic test_saturate();
    do_reset();
    i_req = 1;
    for (int i = 0; i < 14; i++) tick();
    checks++; if (stall_cycles !== 4'd14) begin errors++; $display("FAIL sat_mid: got %0d expected 14", stall_cycles); end
    for (int i = 0; i < 7; i++) tick();
    checks++; if (stall_cycles !== 4'hF) begin errors++; $display("FAIL sat_top: got %0h expected f", stall_cycles); end
    checks++; if (flush_count !== 4'd0) begin errors++; $display("FAIL sat_flush: got %0d expected 0", flush_count); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_pend();
    test_dwait();
    test_reset_in_pend();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
